// File: rtl/rr_arb8_dec.sv
// rr_arb8_dec: 8-way round-robin arbiter with a registered owner index and a one-hot grant decode.
// Build option: define ARB_TIMEOUT_EN to force a release after MAX_HOLD consecutive grant cycles.
module rr_arb8_dec #(
    parameter int MAX_HOLD = 16,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       busy,
    output logic       tmo
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_q, state_n;
    logic [2:0] ptr_q, ptr_n;
    logic [2:0] id_n;
    logic       busy_n;
    logic       rel;
    logic       timeout;
    logic [2:0] scan_ptr;
    logic [3:0] pick;

    if (MAX_HOLD < 1 || MAX_HOLD > 255 || (2 ** CW) <= MAX_HOLD) begin : g_bad_cfg
        $error("rr_arb8_dec: MAX_HOLD must be 1..255 and fit in CW bits");
    end

    // First set bit of r at or after p, wrapping 7 -> 0; bit 3 of the result flags a hit.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] k;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            k = p + 3'(i);
            if (r[k]) res = {1'b1, k};
        end
        return res;
    endfunction

`ifdef ARB_TIMEOUT_EN
    logic [CW-1:0] cnt_q;
    logic          new_gnt;

    assign new_gnt = busy_n && ((state_q == IDLE) || rel);
    assign timeout = (state_q == BUSY) && (cnt_q == CW'(MAX_HOLD - 1)) && !done && req[gnt_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (new_gnt) begin
            cnt_q <= '0;
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n  = state_q;
        ptr_n    = ptr_q;
        id_n     = gnt_id;
        busy_n   = busy;
        rel      = (state_q == BUSY) && (done || !req[gnt_id] || timeout);
        // On release the rescan starts just past the owner, so the owner itself is tried last.
        scan_ptr = (state_q == BUSY) ? gnt_id + 3'd1 : ptr_q;
        pick     = rr_pick(req, scan_ptr);
        case (state_q)
            IDLE: begin
                if (en && pick[3]) begin
                    state_n = BUSY;
                    id_n    = pick[2:0];
                    busy_n  = 1'b1;
                end else begin
                    id_n    = 3'd0;
                    busy_n  = 1'b0;
                end
            end
            BUSY: begin
                if (rel) begin
                    ptr_n = gnt_id + 3'd1;
                    if (en && pick[3]) begin
                        id_n    = pick[2:0];
                        busy_n  = 1'b1;
                    end else begin
                        state_n = IDLE;
                        id_n    = 3'd0;
                        busy_n  = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                id_n    = 3'd0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            gnt_id  <= 3'd0;
            busy    <= 1'b0;
            gnt     <= 8'h00;
            tmo     <= 1'b0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            gnt_id  <= id_n;
            busy    <= busy_n;
            gnt     <= busy_n ? (8'b1 << id_n) : 8'h00;
            tmo     <= timeout;
        end
    end

endmodule

// File: tb/tb_rr_arb8_dec.sv
// Directed testbench for rr_arb8_dec; expected grants are hand-derived from the round-robin rules.
module tb_rr_arb8_dec;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       tmo;

    int nvec = 0;
    int nerr = 0;

    rr_arb8_dec #(.MAX_HOLD(4), .CW(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .req    (req),
        .done   (done),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .tmo    (tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nvec++;
        if (obs !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Advance one edge and sample just after it; grant must always be at most one-hot.
    task automatic step();
        @(posedge clk);
        #1;
        chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
    endtask

    task automatic expect_gnt(input string tag, input logic [7:0] g, input logic b);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 8'h00; done = 1'b0;
        step();
        step();
        expect_gnt("reset", 8'h00, 1'b0);
        chk("reset.id", 32'(gnt_id), 32'd0);
        chk("reset.tmo", 32'(tmo), 32'd0);
        rst = 1'b0;

        // No requests with en high: nothing granted
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_gnt("noreq", 8'h00, 1'b0);
        end

        // Back-to-back hand-offs 2 -> 5 -> 2
        req = 8'h24;
        step();
        expect_gnt("first", 8'h04, 1'b1);
        chk("first.id", 32'(gnt_id), 32'd2);
        step(); expect_gnt("hold2a", 8'h04, 1'b1);
        step(); expect_gnt("hold2b", 8'h04, 1'b1);
        done = 1'b1;
        step();
        done = 1'b0;
        expect_gnt("to5", 8'h20, 1'b1);
        chk("to5.id", 32'(gnt_id), 32'd5);
        step(); expect_gnt("hold5", 8'h20, 1'b1);
        done = 1'b1;
        step();
        done = 1'b0;
        expect_gnt("back2", 8'h04, 1'b1);

        // Reset mid-grant: pointer returns to 0, so requester 2 beats 7
        req = 8'h84;
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_gnt("midrst", 8'h00, 1'b0);
        step();
        expect_gnt("postrst", 8'h04, 1'b1);
        chk("postrst.id", 32'(gnt_id), 32'd2);

        // Owner 7, wrap to 0, then owner 0 drops its request
        do_reset();
        req = 8'h80;
        step(); expect_gnt("own7", 8'h80, 1'b1);
        req = 8'h81;
        step(); expect_gnt("own7hold", 8'h80, 1'b1);
        done = 1'b1;
        step();
        done = 1'b0;
        expect_gnt("wrap0", 8'h01, 1'b1);
        chk("wrap0.id", 32'(gnt_id), 32'd0);
        req = 8'h80;
        step(); expect_gnt("drop0", 8'h80, 1'b1);
        chk("drop0.id", 32'(gnt_id), 32'd7);

        // en gating: no new grant while low, held grant unaffected
        do_reset();
        en = 1'b0; req = 8'hFF;
        step(); expect_gnt("en0a", 8'h00, 1'b0);
        step(); expect_gnt("en0b", 8'h00, 1'b0);
        en = 1'b1;
        step(); expect_gnt("en1", 8'h01, 1'b1);
        en = 1'b0;
        step(); expect_gnt("enhold_a", 8'h01, 1'b1);
        step(); expect_gnt("enhold_b", 8'h01, 1'b1);
        done = 1'b1;
        step();
        done = 1'b0;
        expect_gnt("en0rel", 8'h00, 1'b0);

        // Sole requester 3 re-granted on done, released on request drop
        en = 1'b1; req = 8'h08;
        step(); expect_gnt("sole", 8'h08, 1'b1);
        done = 1'b1;
        step();
        done = 1'b0;
        expect_gnt("regrant", 8'h08, 1'b1);
        chk("regrant.id", 32'(gnt_id), 32'd3);
        step(); expect_gnt("regrant2", 8'h08, 1'b1);
        req = 8'h00;
        step(); expect_gnt("soledrop", 8'h00, 1'b0);

        // Hold limit with two steady requesters
        do_reset();
        req = 8'h03;
        for (int k = 1; k <= 12; k++) begin
`ifdef ARB_TIMEOUT_EN
            logic [7:0] eg;
            logic       et;
            eg = (((k - 1) / 4) % 2 == 0) ? 8'h01 : 8'h02;
            et = (k > 1) && ((k - 1) % 4 == 0);
            step();
            expect_gnt("tmo", eg, 1'b1);
            chk("tmo.pulse", 32'(tmo), 32'(et));
`else
            step();
            expect_gnt("notmo", 8'h01, 1'b1);
            chk("notmo.pulse", 32'(tmo), 32'd0);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
